// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and defaults.
package serial_adder_pkg;

   localparam int SA_WIDTH_DEF = 4;

   // 2'd3 is never entered; the FSM decodes it back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sa_state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell shared by the serial adder datapath.
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic cout,
   output logic sum
);

   // Sum and carry of one bit position.
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks LSB-first through WIDTH bits,
// with the carry registered between cycles and the result assembled in res_sr.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   sa_state_t        state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_cout;
   logic             last_bit;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   fullAdder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .cout (fa_cout),
      .sum  (fa_sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and status decode; unused encoding falls back to IDLE.
   always_comb begin
      state_nxt = ST_IDLE;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: begin
            busy      = 1'b1;
            state_nxt = last_bit ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, per-bit shifting, carry and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr   <= op_a;
                  b_sr   <= op_b;
                  carry  <= cin_in;
                  cnt    <= '0;
                  res_sr <= '0;
               end
            end
            ST_SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
               carry  <= fa_cout;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  sum_out  <= {fa_sum, res_sr[WIDTH-1:1]};
                  cout_out <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4) with hand-computed expectations.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] op_a, op_b;
   logic       cin_in;
   logic       busy, done;
   logic [3:0] sum_out;
   logic       cout_out;

   int n_checks = 0;
   int n_errors = 0;

   serial_adder #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one start at a negedge, then wait (bounded) until done is seen.
   // lat counts negedges from the accept until done; nbusy counts busy cycles.
   task automatic do_add(input logic [3:0] a, input logic [3:0] b, input logic c,
                         output int lat, output int nbusy);
      op_a = a; op_b = b; cin_in = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      nbusy = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) nbusy++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int lat, nbusy, ndone;
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;

      // reset then idle
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res", {cout_out, sum_out}, 0);

      // basic add 3+5
      do_add(4'd3, 4'd5, 1'b0, lat, nbusy);
      chk("basic_res", {cout_out, sum_out}, 8);
      chk("basic_lat", lat, 5);
      chk("basic_busy", nbusy, 5);
      @(negedge clk);
      chk("idle_after_done", busy, 0);
      chk("hold_idle", {cout_out, sum_out}, 8);

      // carry chains
      do_add(4'd15, 4'd1, 1'b0, lat, nbusy);
      chk("carry_15_1", {cout_out, sum_out}, 16);
      @(negedge clk);
      do_add(4'd15, 4'd15, 1'b1, lat, nbusy);
      chk("carry_15_15_1", {cout_out, sum_out}, 31);
      @(negedge clk);

      // start while busy: 2+2 accepted, 7+7 re-pulse during SHIFT ignored
      op_a = 4'd2; op_b = 4'd2; cin_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      op_a = 4'd7; op_b = 4'd7; start = 1'b1;
      chk("hold_shift", {cout_out, sum_out}, 31);
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            ndone++;
            chk("busy_res", {cout_out, sum_out}, 4);
         end
         @(negedge clk);
      end
      chk("busy_ndone", ndone, 1);
      chk("busy_final", {cout_out, sum_out}, 4);

      // reset mid-operation: 9+6, rst on second SHIFT cycle
      op_a = 4'd9; op_b = 4'd6; cin_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort_ndone", ndone, 0);
      chk("abort_res", {cout_out, sum_out}, 0);
      chk("abort_busy", busy, 0);
      do_add(4'd1, 4'd1, 1'b0, lat, nbusy);
      chk("after_abort", {cout_out, sum_out}, 2);
      @(negedge clk);

      // exhaustive back-to-back; start issued the cycle after done
      for (int c = 0; c < 2; c++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               do_add(4'(a), 4'(b), 1'(c), lat, nbusy);
               chk("exh_res", {27'd0, cout_out, sum_out}, 32'(a + b + c));
               if (lat != 5) chk("exh_spacing", lat + 1, 6);
               @(negedge clk);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-cycle adder. It is the control/datapath stage that directly feeds the team's single-bit fullAdder cell.
- It accepts two WIDTH-bit operands plus a carry-in on a start strobe, then presents one LSB-first bit pair per cycle to one fullAdder instance.
- It registers the carry between cycles and assembles the result.
- It produces the same sum/carry as the parallel 4-bit adder, using one cell instead of WIDTH cells.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on accepted start.
- op_b  input  WIDTH  operand B; captured on accepted start.
- cin_in  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- sum_out  output  WIDTH  result sum; held until the next result.
- cout_out  output  1  result carry-out; held with sum_out.

Behaviour:
- Reset (rst=1 at a rising edge, from any state): state=IDLE, busy=0, done=0, sum_out=0, cout_out=0, internal shift registers, carry register and bit counter cleared. Reset overrides start in the same cycle.
- States: IDLE, SHIFT, DONE. Outputs busy and done are decoded from state: busy = (SHIFT|DONE), done = DONE.
- IDLE:
  - start=1 at an edge: a_sr<=op_a, b_sr<=op_b, carry<=cin_in, cnt<=0, res_sr<=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, every edge:
  - fullAdder inputs are a=a_sr[0], b=b_sr[0], cin=carry.
  - a_sr and b_sr shift right by 1.
  - The fullAdder sum shifts into res_sr at the MSB (res_sr <= {sum, res_sr[WIDTH-1:1]}).
  - carry <= fullAdder cout; cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge (the last bit): sum_out <= final res_sr value including this bit, cout_out <= fullAdder cout, go to DONE.
  - SHIFT lasts exactly WIDTH cycles.
- DONE: lasts one cycle (done=1), then unconditionally goes to IDLE.
- Start handling:
  - start during SHIFT or DONE is ignored (not queued).
  - Operand changes after capture have no effect.
- Latency:
  - An accepted start at edge E0 gives done=1 in the cycle following edge E0+WIDTH.
  - The earliest next accepted start is at edge E0+WIDTH+2, giving a throughput of one add per WIDTH+2 cycles.
- Arithmetic: {cout_out, sum_out} == op_a + op_b + cin_in, modulo 2^(WIDTH+1). This is exact with no overflow loss.
- Output holding:
  - sum_out and cout_out change only on entry to DONE or on reset.
  - They stay stable through IDLE and the next SHIFT.
- Reset mid-SHIFT aborts the operation. No done pulse is produced, and sum_out/cout_out read 0.
- cnt width is clog2(WIDTH)+1 bits. It has no wrap-around dependence, because it is cleared on each accept.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 unreachable; it must decode to IDLE);
  - the WIDTH default constant.
- Sub-module: exactly one instance of the existing fullAdder (ports a, b, cin, cout, sum).
- The FSM, shift registers and carry register live in serial_adder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, done=0, sum_out=0, cout_out=0.
- Basic add, WIDTH=4: op_a=3, op_b=5, cin_in=0, start pulse -> done after 5 edges, sum_out=8, cout_out=0; busy high for 5 cycles.
- Carry chain:
  - op_a=15, op_b=1, cin_in=0 -> sum_out=0, cout_out=1.
  - op_a=15, op_b=15, cin_in=1 -> sum_out=15, cout_out=1.
- Start while busy: accept 2+2; re-pulse start with 7+7 during SHIFT -> single done, sum_out=4; no second done pulse.
- Reset mid-operation: start 9+6, assert rst at 2nd SHIFT cycle -> no done pulse, sum_out=0, cout_out=0, state IDLE. A subsequent 1+1 then gives sum_out=2.
- Exhaustive back-to-back: all 512 (op_a, op_b, cin_in) combos, each start issued the cycle after done -> every result matches op_a+op_b+cin_in; spacing is exactly 6 cycles per add.
